// File: rtl/shape_raster_core.sv
// Shape rasteriser: accepts one opcode (line / filled rectangle / single
// pixel), walks it pixel by pixel and presents each on-screen pixel as a
// framebuffer address + colour over a data_ready/data_sent handshake.
// Off-screen pixels are skipped at one step per cycle.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   new_shape    opcode valid, sampled only while idle
//   full_opcode  {frame, color, y1, x1, y0, x0, mode[3:0]} (LSB first: mode)
//   data_sent    downstream consumed the presented pixel
//   data_ready   address/color hold a valid pixel
//   address      y*SCREEN_W + x of the current pixel
//   color        colour latched from the accepted opcode
//   frame_target target buffer latched from the accepted opcode
//   busy         high whenever not idle
//   shape_done   one-cycle pulse when a shape completes
module shape_raster_core #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned COLOR_W  = 16,
  localparam int unsigned OP_W    = 5 + 2*X_W + 2*Y_W + COLOR_W
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               new_shape,
  input  logic [OP_W-1:0]    full_opcode,
  input  logic               data_sent,
  output logic               data_ready,
  output logic [ADDR_W-1:0]  address,
  output logic [COLOR_W-1:0] color,
  output logic               frame_target,
  output logic               busy,
  output logic               shape_done
);

  localparam int unsigned SW    = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int unsigned C_LSB = 4 + 2*X_W + 2*Y_W;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;
  state_t state;

  // latched opcode fields
  logic [3:0]     mode;
  logic [X_W-1:0] x0, x1;
  logic [Y_W-1:0] y0, y1;

  // walker state
  logic [X_W-1:0]       cx, x_lo, x_end;
  logic [Y_W-1:0]       cy, y_end;
  logic signed [SW-1:0] dx, dy, err;
  logic                 sx_neg, sy_neg, is_line;

  // combinational setup / step values
  logic signed [SW-1:0] ddx, ddy, adx, ady, err_n;
  logic signed [SW:0]   e2, dx_e, dy_e;
  logic [X_W-1:0]       rx_lo, rx_hi, nx, ld_x;
  logic [Y_W-1:0]       ry_lo, ry_hi, ny, ld_y;
  logic                 step_x, step_y, last, adv;

  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
  endfunction

  always_comb begin
    ddx   = $signed(SW'(x1)) - $signed(SW'(x0));
    ddy   = $signed(SW'(y1)) - $signed(SW'(y0));
    adx   = ddx[SW-1] ? -ddx : ddx;
    ady   = ddy[SW-1] ? -ddy : ddy;
    rx_lo = (x0 < x1) ? x0 : x1;
    rx_hi = (x0 < x1) ? x1 : x0;
    ry_lo = (y0 < y1) ? y0 : y1;
    ry_hi = (y0 < y1) ? y1 : y0;

    // Bresenham decision uses the pre-update error for both axes
    e2     = {err, 1'b0};
    dx_e   = {dx[SW-1], dx};
    dy_e   = {dy[SW-1], dy};
    step_x = (e2 >= dy_e);
    step_y = (e2 <= dx_e);
    err_n  = err;
    if (step_x) err_n = err_n + dy;
    if (step_y) err_n = err_n + dx;

    // every mode ends when the walker reaches (x_end, y_end)
    last = (cx == x_end) && (cy == y_end);
    adv  = !data_ready || data_sent;

    nx = cx;
    ny = cy;
    if (is_line) begin
      if (step_x) nx = sx_neg ? cx - X_W'(1) : cx + X_W'(1);
      if (step_y) ny = sy_neg ? cy - Y_W'(1) : cy + Y_W'(1);
    end else if (cx == x_end) begin
      nx = x_lo;
      ny = cy + Y_W'(1);
    end else begin
      nx = cx + X_W'(1);
    end

    if (state == SETUP) begin
      ld_x = (mode == 4'd1) ? rx_lo : x0;
      ld_y = (mode == 4'd1) ? ry_lo : y0;
    end else begin
      ld_x = nx;
      ld_y = ny;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      mode         <= '0;
      x0           <= '0;
      x1           <= '0;
      y0           <= '0;
      y1           <= '0;
      cx           <= '0;
      cy           <= '0;
      x_lo         <= '0;
      x_end        <= '0;
      y_end        <= '0;
      dx           <= '0;
      dy           <= '0;
      err          <= '0;
      sx_neg       <= 1'b0;
      sy_neg       <= 1'b0;
      is_line      <= 1'b0;
      data_ready   <= 1'b0;
      address      <= '0;
      color        <= '0;
      frame_target <= 1'b0;
      busy         <= 1'b0;
      shape_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (new_shape) begin
            mode         <= full_opcode[3:0];
            x0           <= full_opcode[4 +: X_W];
            y0           <= full_opcode[4+X_W +: Y_W];
            x1           <= full_opcode[4+X_W+Y_W +: X_W];
            y1           <= full_opcode[4+2*X_W+Y_W +: Y_W];
            color        <= full_opcode[C_LSB +: COLOR_W];
            frame_target <= full_opcode[OP_W-1];
            busy         <= 1'b1;
            state        <= SETUP;
          end
        end
        SETUP: begin
          if (mode <= 4'd2) begin
            is_line    <= (mode == 4'd0);
            dx         <= adx;
            dy         <= -ady;
            err        <= adx - ady;
            sx_neg     <= ddx[SW-1];
            sy_neg     <= ddy[SW-1];
            x_lo       <= rx_lo;
            cx         <= ld_x;
            cy         <= ld_y;
            address    <= addr_of(ld_x, ld_y);
            data_ready <= on_screen(ld_x, ld_y);
            case (mode)
              4'd0:    begin x_end <= x1;    y_end <= y1;    end
              4'd1:    begin x_end <= rx_hi; y_end <= ry_hi; end
              default: begin x_end <= x0;    y_end <= y0;    end
            endcase
            state <= DRAW;
          end else begin
            shape_done <= 1'b1;
            state      <= DONE;
          end
        end
        DRAW: begin
          if (adv) begin
            if (last) begin
              data_ready <= 1'b0;
              shape_done <= 1'b1;
              state      <= DONE;
            end else begin
              cx         <= ld_x;
              cy         <= ld_y;
              err        <= err_n;
              address    <= addr_of(ld_x, ld_y);
              data_ready <= on_screen(ld_x, ld_y);
            end
          end
        end
        DONE: begin
          shape_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
